// File: rtl/gate_stream_encoder.sv
// Serializes one garbled-gate record into the byte stream consumed by the gate
// deserializer, with first/last byte markers for SPI framing.
module gate_stream_encoder #(
  parameter int ID_BYTES   = 3,
  parameter int CTXT_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    gate_valid,
  output logic                    gate_ready,
  input  logic [1:0]              gate_type,
  input  logic [8*ID_BYTES-1:0]   id_1,
  input  logic [8*ID_BYTES-1:0]   id_2,
  input  logic [8*ID_BYTES-1:0]   gate_id,
  input  logic [8*CTXT_BYTES-1:0] ctxt_1,
  input  logic [8*CTXT_BYTES-1:0] ctxt_2,
  input  logic [8*CTXT_BYTES-1:0] ctxt_3,
  output logic [7:0]              out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_first,
  output logic                    out_last,
  output logic                    error
);

  localparam int MAX_BYTES = (ID_BYTES > CTXT_BYTES) ? ID_BYTES : CTXT_BYTES;
  localparam int CNT_W     = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [CNT_W-1:0] ID_LAST   = CNT_W'(ID_BYTES - 1);
  localparam logic [CNT_W-1:0] CTXT_LAST = CNT_W'(CTXT_BYTES - 1);
  localparam logic [1:0] T_AND = 2'd0;
  localparam logic [1:0] T_BUF = 2'd2;
  localparam logic [1:0] T_ILL = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_ID1, S_ID2, S_CTXT, S_GID} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [1:0]         idx, idx_nxt;
  logic               err, err_nxt;
  logic               hs;
  logic               accept;

  logic [1:0]              type_p0;
  logic [8*ID_BYTES-1:0]   id1_p0, id2_p0, gid_p0;
  logic [8*CTXT_BYTES-1:0] ctxt1_p0, ctxt2_p0, ctxt3_p0;

  function automatic logic [7:0] id_byte(input logic [8*ID_BYTES-1:0] v,
                                         input logic [CNT_W-1:0] i);
    return 8'(v >> {i, 3'b000});
  endfunction

  function automatic logic [7:0] ctxt_byte(input logic [8*CTXT_BYTES-1:0] v,
                                           input logic [CNT_W-1:0] i);
    return 8'(v >> {i, 3'b000});
  endfunction

  assign hs     = (state != S_IDLE) && out_ready;
  assign accept = (state == S_IDLE) && gate_valid;

  // Record latch: inputs are don't-care once accepted
  always_ff @(posedge clk) begin
    if (accept) begin
      type_p0  <= gate_type;
      id1_p0   <= id_1;
      id2_p0   <= id_2;
      gid_p0   <= gate_id;
      ctxt1_p0 <= ctxt_1;
      ctxt2_p0 <= ctxt_2;
      ctxt3_p0 <= ctxt_3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= 2'd1;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: if (gate_valid) begin
        if (gate_type == T_ILL) begin
          err_nxt = 1'b1;
        end else begin
          state_nxt = S_HDR;
          cnt_nxt   = '0;
        end
      end
      S_HDR: if (hs) begin
        state_nxt = S_ID1;
        cnt_nxt   = '0;
      end
      S_ID1: if (hs) begin
        if (cnt == ID_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (type_p0 == T_BUF) ? S_IDLE : S_ID2;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_ID2: if (hs) begin
        if (cnt == ID_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = 2'd1;
          state_nxt = (type_p0 == T_AND) ? S_CTXT : S_GID;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_CTXT: if (hs) begin
        if (cnt == CTXT_LAST) begin
          cnt_nxt = '0;
          if (idx == 2'd3) state_nxt = S_GID;
          else             idx_nxt   = idx + 2'd1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_GID: if (hs) begin
        if (cnt == ID_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state, so they hold through sink stalls
  always_comb begin
    gate_ready = (state == S_IDLE);
    out_valid  = (state != S_IDLE);
    out_first  = (state == S_HDR);
    out_last   = ((state == S_ID1) && (type_p0 == T_BUF) && (cnt == ID_LAST)) ||
                 ((state == S_GID) && (cnt == ID_LAST));
    error      = err;
    out_data   = 8'h00;
    case (state)
      S_HDR:  out_data = {6'b0, type_p0};
      S_ID1:  out_data = id_byte(id1_p0, cnt);
      S_ID2:  out_data = id_byte(id2_p0, cnt);
      S_CTXT: begin
        case (idx)
          2'd1:    out_data = ctxt_byte(ctxt1_p0, cnt);
          2'd2:    out_data = ctxt_byte(ctxt2_p0, cnt);
          default: out_data = ctxt_byte(ctxt3_p0, cnt);
        endcase
      end
      S_GID:  out_data = id_byte(gid_p0, cnt);
      default: out_data = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_gate_stream_encoder.sv
// Directed bench for gate_stream_encoder: XOR/AND/BUF streams, backpressure,
// illegal type, mid-record reset and back-to-back records.
module tb_gate_stream_encoder;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         gate_valid = 1'b0;
  logic         gate_ready;
  logic [1:0]   gate_type = 2'd0;
  logic [23:0]  id_1 = '0, id_2 = '0, gate_id = '0;
  logic [127:0] ctxt_1 = '0, ctxt_2 = '0, ctxt_3 = '0;
  logic [7:0]   out_data;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         out_first, out_last, error;

  gate_stream_encoder #(.ID_BYTES(3), .CTXT_BYTES(16)) dut (
    .clk(clk), .rst_n(rst_n), .gate_valid(gate_valid), .gate_ready(gate_ready),
    .gate_type(gate_type), .id_1(id_1), .id_2(id_2), .gate_id(gate_id),
    .ctxt_1(ctxt_1), .ctxt_2(ctxt_2), .ctxt_3(ctxt_3),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] got[$];
  bit         gf[$];
  bit         gl[$];
  logic [7:0] exp_q[$];

  int         rmode = 0;
  int         stall_left = 0;
  bit         stalled_once = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data = '0;
  logic       prev_f = 1'b0, prev_l = 1'b0;
  bit         last_seen = 0;
  bit         chk_gap = 0;
  int         gap = 0;

  logic [127:0] c1, c2, c3;

  // Reference stream: header, id_1, [id_2], [ctxt_1..3], [gate_id], LSB first
  function automatic void add_exp(input logic [1:0] t, input logic [23:0] i1, i2, g,
                                  input logic [127:0] k1, k2, k3);
    exp_q.push_back({6'b0, t});
    for (int b = 0; b < 3; b++) exp_q.push_back(i1[8*b +: 8]);
    if (t != 2'd2) for (int b = 0; b < 3; b++) exp_q.push_back(i2[8*b +: 8]);
    if (t == 2'd0) begin
      for (int b = 0; b < 16; b++) exp_q.push_back(k1[8*b +: 8]);
      for (int b = 0; b < 16; b++) exp_q.push_back(k2[8*b +: 8]);
      for (int b = 0; b < 16; b++) exp_q.push_back(k3[8*b +: 8]);
    end
    if (t != 2'd2) for (int b = 0; b < 3; b++) exp_q.push_back(g[8*b +: 8]);
  endfunction

  task automatic clr();
    got.delete(); gf.delete(); gl.delete(); exp_q.delete();
    last_seen = 0;
  endtask

  // One cycle: sample at negedge, decide out_ready for the next posedge, capture handshake
  task automatic tick();
    @(negedge clk);
    if (prev_stall) begin
      checks++;
      if (!out_valid || out_data !== prev_data || out_first !== prev_f || out_last !== prev_l) begin
        errors++;
        $display("FAIL hold: valid=%b data=%h first=%b last=%b required valid=1 data=%h first=%b last=%b",
                 out_valid, out_data, out_first, out_last, prev_data, prev_f, prev_l);
      end
    end
    if (rmode == 0) out_ready = 1'b1;
    else if (stall_left > 0) begin out_ready = 1'b0; stall_left--; end
    else if (!stalled_once && out_valid && got.size() == 23) begin
      stalled_once = 1; stall_left = 24; out_ready = 1'b0;
    end
    else out_ready = ($urandom_range(0, 2) != 0);
    if (!out_valid) gap++;
    if (out_valid && out_ready) begin
      if (chk_gap && out_first && got.size() > 0) begin
        checks++;
        if (gap != 1) begin
          errors++;
          $display("FAIL gap: idle cycles=%0d required 1", gap);
        end
      end
      got.push_back(out_data); gf.push_back(out_first); gl.push_back(out_last);
      if (out_last) begin last_seen = 1; gap = 0; end
    end
    prev_stall = out_valid && !out_ready;
    prev_data = out_data; prev_f = out_first; prev_l = out_last;
  endtask

  task automatic start_rec(input logic [1:0] t, input logic [23:0] i1, i2, g,
                           input logic [127:0] k1, k2, k3, input bit keep);
    gate_type = t; id_1 = i1; id_2 = i2; gate_id = g;
    ctxt_1 = k1; ctxt_2 = k2; ctxt_3 = k3;
    gate_valid = 1'b1;
    for (int k = 0; k < 200 && !gate_ready; k++) tick();
    if (!gate_ready) begin
      checks++; errors++;
      $display("FAIL accept: gate_ready=%b required 1 within 200 cycles", gate_ready);
    end
    tick();
    if (!keep) gate_valid = 1'b0;
  endtask

  task automatic wait_last(input int budget);
    for (int k = 0; k < budget && !last_seen; k++) tick();
    checks++;
    if (!last_seen) begin
      errors++;
      $display("FAIL last_timeout: out_last seen=%b required 1 within %0d cycles", last_seen, budget);
    end
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_first, out_last, error} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b data=%h first=%b last=%b error=%b required all 0",
               out_valid, out_data, out_first, out_last, error);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (gate_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: gate_ready=%b out_valid=%b required 1 0", gate_ready, out_valid);
    end
  endtask

  task automatic test_xor();
    logic [7:0] xr [10] = '{8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
    int nf;
    int nl;
    clr();
    start_rec(2'd1, 24'h030201, 24'h060504, 24'h090807, '0, '0, '0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_first !== 1'b1 || out_data !== 8'h01) begin
      errors++;
      $display("FAIL xor_latency: valid=%b first=%b data=%h required 1 1 01", out_valid, out_first, out_data);
    end
    wait_last(50);
    checks++;
    if (got.size() != 10) begin
      errors++; $display("FAIL xor_len: got %0d bytes required 10", got.size());
    end
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== xr[i]) begin
        errors++; $display("FAIL xor_byte%0d: got %h required %h", i, got[i], xr[i]);
      end
    end
    nf = 0; nl = 0;
    foreach (gf[i]) nf += int'(gf[i]);
    foreach (gl[i]) nl += int'(gl[i]);
    checks++;
    if (got.size() == 10 && (!gf[0] || !gl[9] || nf != 1 || nl != 1)) begin
      errors++;
      $display("FAIL xor_markers: first0=%b last9=%b nfirst=%0d nlast=%0d required 1 1 1 1", gf[0], gl[9], nf, nl);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || gate_ready !== 1'b1) begin
      errors++; $display("FAIL xor_done: out_valid=%b gate_ready=%b required 0 1", out_valid, gate_ready);
    end
  endtask

  task automatic test_and();
    clr();
    add_exp(2'd0, 24'hA3A2A1, 24'hB3B2B1, 24'hC3C2C1, c1, c2, c3);
    start_rec(2'd0, 24'hA3A2A1, 24'hB3B2B1, 24'hC3C2C1, c1, c2, c3, 0);
    wait_last(200);
    checks++;
    if (got.size() != 58) begin
      errors++; $display("FAIL and_len: got %0d bytes required 58", got.size());
    end
    for (int i = 0; i < 58 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++; $display("FAIL and_byte%0d: got %h required %h", i, got[i], exp_q[i]);
      end
    end
    if (got.size() == 58) begin
      for (int i = 7; i <= 54; i++) begin
        checks++;
        if (got[i] !== 8'(i - 7)) begin
          errors++; $display("FAIL and_ctxt%0d: got %h required %h", i, got[i], 8'(i - 7));
        end
      end
      checks++;
      if ({got[0], got[1], got[55], got[56], got[57]} !== 40'h00A1C1C2C3 || !gl[57] || gl[54]) begin
        errors++;
        $display("FAIL and_frame: hdr=%h id0=%h tail=%h%h%h last57=%b required 00 A1 C1C2C3 1",
                 got[0], got[1], got[55], got[56], got[57], gl[57]);
      end
    end
  endtask

  task automatic test_buf();
    clr();
    start_rec(2'd2, 24'hABCDEF, 24'h5A5A5A, 24'h777777, c1, c2, c3, 0);
    wait_last(50);
    repeat (3) tick();
    checks++;
    if (got.size() != 4) begin
      errors++; $display("FAIL buf_len: got %0d bytes required 4", got.size());
    end else begin
      checks++;
      if ({got[0], got[1], got[2], got[3]} !== 32'h02EFCDAB) begin
        errors++;
        $display("FAIL buf_bytes: got %h %h %h %h required 02 EF CD AB", got[0], got[1], got[2], got[3]);
      end
      checks++;
      if ({gf[0], gf[3], gl[0], gl[3]} !== 4'b1001) begin
        errors++;
        $display("FAIL buf_markers: f0=%b f3=%b l0=%b l3=%b required 1 0 0 1", gf[0], gf[3], gl[0], gl[3]);
      end
    end
  endtask

  task automatic test_backpressure();
    clr();
    add_exp(2'd0, 24'h121110, 24'h252423, 24'h383736, c1, c2, c3);
    rmode = 1; stalled_once = 0; stall_left = 0;
    start_rec(2'd0, 24'h121110, 24'h252423, 24'h383736, c1, c2, c3, 0);
    wait_last(2000);
    rmode = 0;
    checks++;
    if (!stalled_once) begin
      errors++; $display("FAIL bp_stall: long stall at ctxt boundary=%b required 1", stalled_once);
    end
    checks++;
    if (got.size() != 58) begin
      errors++; $display("FAIL bp_len: got %0d bytes required 58", got.size());
    end
    for (int i = 0; i < 58 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++; $display("FAIL bp_byte%0d: got %h required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_illegal();
    clr();
    start_rec(2'd3, 24'h010101, 24'h020202, 24'h030303, c1, c2, c3, 0);
    checks++;
    if (error !== 1'b1 || out_valid !== 1'b0 || gate_ready !== 1'b1) begin
      errors++;
      $display("FAIL illegal_pulse: error=%b out_valid=%b gate_ready=%b required 1 0 1", error, out_valid, gate_ready);
    end
    tick();
    checks++;
    if (error !== 1'b0) begin
      errors++; $display("FAIL illegal_width: error=%b required 0", error);
    end
    repeat (4) tick();
    checks++;
    if (got.size() != 0) begin
      errors++; $display("FAIL illegal_bytes: got %0d bytes required 0", got.size());
    end
  endtask

  task automatic test_reset_mid();
    clr();
    start_rec(2'd0, 24'h999999, 24'h888888, 24'h777777, c1, c2, c3, 0);
    for (int k = 0; k < 100 && got.size() < 21; k++) tick();
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_data, out_first, out_last, error} !== 12'h000) begin
      errors++;
      $display("FAIL midrst_outputs: valid=%b data=%h first=%b last=%b error=%b required all 0",
               out_valid, out_data, out_first, out_last, error);
    end
    @(negedge clk); @(negedge clk);
    checks++;
    if ({out_valid, out_data, out_first, out_last} !== 11'h000) begin
      errors++;
      $display("FAIL midrst_hold: valid=%b data=%h first=%b last=%b required all 0",
               out_valid, out_data, out_first, out_last);
    end
    rst_n = 1'b1;
    prev_stall = 0;
    clr();
    repeat (3) tick();
    checks++;
    if (got.size() != 0 || gate_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_idle: bytes=%0d gate_ready=%b required 0 1", got.size(), gate_ready);
    end
    add_exp(2'd1, 24'h030201, 24'h060504, 24'h090807, '0, '0, '0);
    start_rec(2'd1, 24'h030201, 24'h060504, 24'h090807, '0, '0, '0, 0);
    wait_last(50);
    repeat (2) tick();
    checks++;
    if (got.size() != 10) begin
      errors++; $display("FAIL midrst_len: got %0d bytes required 10", got.size());
    end
    for (int i = 0; i < 10 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++; $display("FAIL midrst_byte%0d: got %h required %h", i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nf;
    int nl;
    clr();
    chk_gap = 1; gap = 0;
    add_exp(2'd1, 24'h232221, 24'h262524, 24'h292827, '0, '0, '0);
    add_exp(2'd2, 24'h313233, 24'h000000, 24'h000000, '0, '0, '0);
    add_exp(2'd0, 24'h414243, 24'h444546, 24'h474849, c1, c2, c3);
    start_rec(2'd1, 24'h232221, 24'h262524, 24'h292827, '0, '0, '0, 1);
    start_rec(2'd2, 24'h313233, 24'h000000, 24'h000000, '0, '0, '0, 1);
    start_rec(2'd0, 24'h414243, 24'h444546, 24'h474849, c1, c2, c3, 0);
    last_seen = 0;
    wait_last(300);
    chk_gap = 0;
    checks++;
    if (got.size() != 72) begin
      errors++; $display("FAIL b2b_len: got %0d bytes required 72", got.size());
    end
    for (int i = 0; i < 72 && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++; $display("FAIL b2b_byte%0d: got %h required %h", i, got[i], exp_q[i]);
      end
    end
    nf = 0; nl = 0;
    foreach (gf[i]) nf += int'(gf[i]);
    foreach (gl[i]) nl += int'(gl[i]);
    checks++;
    if (nf != 3 || nl != 3) begin
      errors++; $display("FAIL b2b_markers: nfirst=%0d nlast=%0d required 3 3", nf, nl);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      c1[8*i +: 8] = 8'(i);
      c2[8*i +: 8] = 8'(i + 16);
      c3[8*i +: 8] = 8'(i + 32);
    end
    test_reset();
    test_xor();
    test_and();
    test_buf();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
